mux_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller around the 4:1 8-bit display mux.

---
 rtl/disp_pkg.sv | 31 +++
 rtl/mux_scan_ctrl_slot_timer.sv | 47 ++++
 rtl/mux_scan_ctrl.sv | 107 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared types and constants for the multiplexed display scan.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    localparam int NUM_DIGITS       = 4;
    localparam int SEL_W            = 2;
    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_BLANK_CYCLES = 16;

    localparam logic [NUM_DIGITS-1:0] ALL_OFF = 4'b1111;

    // Active-low one-hot enable for the digit addressed by sel.
    function automatic logic [NUM_DIGITS-1:0] digit_en_of(input logic [SEL_W-1:0] sel);
        logic [NUM_DIGITS-1:0] onehot;
        onehot = 4'b0001 << sel;
        return ~onehot;
    endfunction

endpackage : disp_pkg
`default_nettype wire

// File: rtl/mux_scan_ctrl_slot_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : slot_timer
// Description : Per-digit slot counter; strobes the last blank cycle and the
//               last cycle of the slot. Held at zero while not running.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_timer #(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic blank_end_o,
    output logic slot_end_o
);

    localparam int K_W = $clog2(TICK_DIV);
    localparam logic [K_W-1:0] c_blank_last = K_W'(BLANK_CYCLES - 1);
    localparam logic [K_W-1:0] c_slot_last  = K_W'(TICK_DIV - 1);

    logic [K_W-1:0] k_q;
    logic [K_W-1:0] k_d;

    assign blank_end_o = run_i && (k_q == c_blank_last);
    assign slot_end_o  = run_i && (k_q == c_slot_last);

    // Wrap happens only through the last-cycle compare, so no overflow path exists.
    always_comb begin
        k_d = '0;
        if (run_i && !slot_end_o) begin
            k_d = k_q + K_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

endmodule : slot_timer
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Time-multiplexed scan controller for a 4:1 display mux with
//               inter-digit blanking and a per-frame pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl
    import disp_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int DATA_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  hold,
    input  logic [DATA_W-1:0]     mux_f,
    output logic [SEL_W-1:0]      sel,
    output logic [DATA_W-1:0]     seg_out,
    output logic [NUM_DIGITS-1:0] digit_en_n,
    output logic                  frame_done
);

    localparam logic [SEL_W-1:0] c_last_sel = SEL_W'(NUM_DIGITS - 1);

    state_e                  state_q;
    logic [SEL_W-1:0]        sel_q;
    logic [DATA_W-1:0]       seg_q;
    logic [NUM_DIGITS-1:0]   den_q;
    logic                    frame_q;

    logic                    w_run;
    logic                    w_blank_end;
    logic                    w_slot_end;

    assign w_run = enable && (state_q != IDLE);

    slot_timer #(
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_i       (w_run),
        .blank_end_o (w_blank_end),
        .slot_end_o  (w_slot_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            seg_q   <= '0;
            den_q   <= ALL_OFF;
            frame_q <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (!enable) begin
                state_q <= IDLE;
                sel_q   <= '0;
                seg_q   <= '0;
                den_q   <= ALL_OFF;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= BLANK;
                        sel_q   <= '0;
                    end
                    BLANK: begin
                        // sel has been stable for the whole blank, so mux_f is settled.
                        if (w_blank_end) begin
                            seg_q   <= mux_f;
                            den_q   <= digit_en_of(sel_q);
                            state_q <= SHOW;
                        end
                    end
                    SHOW: begin
                        if (w_slot_end) begin
                            den_q   <= ALL_OFF;
                            state_q <= BLANK;
                            if (!hold) begin
                                sel_q   <= sel_q + SEL_W'(1);
                                frame_q <= (sel_q == c_last_sel);
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        sel_q   <= '0;
                        seg_q   <= '0;
                        den_q   <= ALL_OFF;
                    end
                endcase
            end
        end
    end

    assign sel        = sel_q;
    assign seg_out    = seg_q;
    assign digit_en_n = den_q;
    assign frame_done = frame_q;

endmodule : mux_scan_ctrl
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Directed self-checking bench for mux_scan_ctrl with a 4:1 mux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

    localparam int TD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] mux_f;
    logic [1:0] sel;
    logic [7:0] seg_out;
    logic [3:0] digit_en_n;
    logic       frame_done;

    logic [7:0] in_a = 8'h11;
    logic [7:0] in_b = 8'h22;
    logic [7:0] in_c = 8'h33;
    logic [7:0] in_d = 8'h44;

    int vectors = 0;
    int miscompares = 0;

    // Display mux: sw=1 selects C, sw=2 selects B.
    always_comb begin
        case (sel)
            2'd0:    mux_f = in_a;
            2'd1:    mux_f = in_c;
            2'd2:    mux_f = in_b;
            default: mux_f = in_d;
        endcase
    end

    mux_scan_ctrl #(
        .TICK_DIV     (TD),
        .BLANK_CYCLES (BC),
        .DATA_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .hold       (hold),
        .mux_f      (mux_f),
        .sel        (sel),
        .seg_out    (seg_out),
        .digit_en_n (digit_en_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_data(input int s);
        case (s)
            0:       return 8'h11;
            1:       return 8'h33;
            2:       return 8'h22;
            default: return 8'h44;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Continuous display-safety checks.
    logic [1:0] last_sel = 2'd0;
    int         since = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            since    = 0;
            last_sel = sel;
        end else begin
            if (sel !== last_sel) since = 0;
            else if (since < 1000) since++;
            last_sel = sel;
            vectors++;
            if ($countones(~digit_en_n) > 1) begin
                miscompares++;
                $display("FAIL onehot: digit_en_n=%b want at most one low bit", digit_en_n);
            end
            vectors++;
            if (digit_en_n !== 4'hF && since < BC) begin
                miscompares++;
                $display("FAIL blank_gap: lit %0d cycles after sel change want >= %0d", since, BC);
            end
            vectors++;
            if (digit_en_n !== 4'hF && digit_en_n !== ~(4'b0001 << sel)) begin
                miscompares++;
                $display("FAIL lit_index: digit_en_n=%b sel=%0d want digit matching sel", digit_en_n, sel);
            end
        end
    end

    task automatic test_reset;
        rst_n  = 1'b0;
        enable = 1'b0;
        step(2);
        vectors++;
        if (sel !== 2'd0) begin miscompares++; $display("FAIL reset_sel: got %0d want 0", sel); end
        vectors++;
        if (seg_out !== 8'h00) begin miscompares++; $display("FAIL reset_seg: got %h want 00", seg_out); end
        vectors++;
        if (digit_en_n !== 4'hF) begin miscompares++; $display("FAIL reset_den: got %b want 1111", digit_en_n); end
        vectors++;
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame: got %b want 0", frame_done); end
        rst_n = 1'b1;
        step(2);
        vectors++;
        if (digit_en_n !== 4'hF || sel !== 2'd0) begin
            miscompares++;
            $display("FAIL idle_disabled: den=%b sel=%0d want 1111 and 0", digit_en_n, sel);
        end
    endtask

    task automatic test_scan;
        logic [3:0] onehot;
        logic [3:0] exp_den;
        enable = 1'b1;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < TD; k++) begin
                step(1);
                onehot  = 4'b0001 << s;
                exp_den = (k < BC) ? 4'hF : ~onehot;
                vectors++;
                if (sel !== 2'(s)) begin miscompares++; $display("FAIL scan_sel s%0d k%0d: got %0d want %0d", s, k, sel, s); end
                vectors++;
                if (digit_en_n !== exp_den) begin miscompares++; $display("FAIL scan_den s%0d k%0d: got %b want %b", s, k, digit_en_n, exp_den); end
                vectors++;
                if (frame_done !== 1'b0) begin miscompares++; $display("FAIL scan_frame s%0d k%0d: got %b want 0", s, k, frame_done); end
                if (k >= BC) begin
                    vectors++;
                    if (seg_out !== exp_data(s)) begin miscompares++; $display("FAIL scan_seg s%0d k%0d: got %h want %h", s, k, seg_out, exp_data(s)); end
                end
                // Input changes mid-SHOW must not reach seg_out.
                if (s == 0 && k == 3) in_a = 8'h99;
                if (s == 0 && k == 6) in_a = 8'h11;
            end
        end
        step(1);
        vectors++;
        if (frame_done !== 1'b1) begin miscompares++; $display("FAIL frame_pulse: got %b want 1", frame_done); end
        vectors++;
        if (sel !== 2'd0 || digit_en_n !== 4'hF) begin miscompares++; $display("FAIL frame_wrap: sel=%0d den=%b want 0 and 1111", sel, digit_en_n); end
        step(1);
        vectors++;
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL frame_width: got %b want 0", frame_done); end
    endtask

    task automatic test_hold;
        step(7);
        step(8);
        vectors++;
        if (sel !== 2'd2) begin miscompares++; $display("FAIL hold_pre_sel: got %0d want 2", sel); end
        step(2);
        vectors++;
        if (seg_out !== 8'h22 || digit_en_n !== 4'b1011) begin
            miscompares++;
            $display("FAIL hold_pre_show: seg=%h den=%b want 22 and 1011", seg_out, digit_en_n);
        end
        hold = 1'b1;
        step(1);
        // Both inputs that could sit behind sel=2 get the new value.
        in_b = 8'h5A;
        in_c = 8'h5A;
        step(4);
        vectors++;
        if (seg_out !== 8'h22) begin miscompares++; $display("FAIL hold_ignore_in: got %h want 22", seg_out); end
        step(1);
        vectors++;
        if (sel !== 2'd2) begin miscompares++; $display("FAIL hold_sel: got %0d want 2", sel); end
        vectors++;
        if (digit_en_n !== 4'hF) begin miscompares++; $display("FAIL hold_blank: got %b want 1111", digit_en_n); end
        vectors++;
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL hold_frame: got %b want 0", frame_done); end
        hold = 1'b0;
        step(2);
        vectors++;
        if (seg_out !== 8'h5A || digit_en_n !== 4'b1011) begin
            miscompares++;
            $display("FAIL hold_resample: seg=%h den=%b want 5a and 1011", seg_out, digit_en_n);
        end
        in_b = 8'h22;
        in_c = 8'h33;
        step(6);
        vectors++;
        if (sel !== 2'd3 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release: sel=%0d frame=%b want 3 and 0", sel, frame_done);
        end
    endtask

    task automatic test_enable_drop;
        step(4);
        vectors++;
        if (seg_out !== 8'h44 || digit_en_n !== 4'b0111) begin
            miscompares++;
            $display("FAIL drop_pre: seg=%h den=%b want 44 and 0111", seg_out, digit_en_n);
        end
        enable = 1'b0;
        hold   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            vectors++;
            if (digit_en_n !== 4'hF || seg_out !== 8'h00 || sel !== 2'd0 || frame_done !== 1'b0) begin
                miscompares++;
                $display("FAIL drop_idle c%0d: den=%b seg=%h sel=%0d frame=%b want 1111 00 0 0", i, digit_en_n, seg_out, sel, frame_done);
            end
        end
        hold   = 1'b0;
        enable = 1'b1;
        step(1);
        vectors++;
        if (sel !== 2'd0 || digit_en_n !== 4'hF || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reenable_k0: sel=%0d den=%b frame=%b want 0 1111 0", sel, digit_en_n, frame_done);
        end
        step(1);
        vectors++;
        if (digit_en_n !== 4'hF) begin miscompares++; $display("FAIL reenable_k1: got %b want 1111", digit_en_n); end
        step(1);
        vectors++;
        if (seg_out !== 8'h11 || digit_en_n !== 4'b1110) begin
            miscompares++;
            $display("FAIL reenable_show: seg=%h den=%b want 11 and 1110", seg_out, digit_en_n);
        end
    endtask

    task automatic test_async_reset;
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (digit_en_n !== 4'hF || seg_out !== 8'h00 || sel !== 2'd0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: den=%b seg=%h sel=%0d frame=%b want 1111 00 0 0", digit_en_n, seg_out, sel, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        vectors++;
        if (sel !== 2'd0 || digit_en_n !== 4'hF || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_k0: sel=%0d den=%b frame=%b want 0 1111 0", sel, digit_en_n, frame_done);
        end
        step(2);
        vectors++;
        if (seg_out !== 8'h11 || digit_en_n !== 4'b1110) begin
            miscompares++;
            $display("FAIL post_reset_show: seg=%h den=%b want 11 and 1110", seg_out, digit_en_n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_scan();
        test_hold();
        test_enable_drop();
        test_async_reset();
        step(1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mux_scan_ctrl
`default_nettype wire
